div_unit: RTL and testbench



---
 rtl/div_unit.sv | 134 +++++++++++++
 tb/tb_div_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Sequential signed 32-bit restoring divider: quotient on lo, remainder on hi.
// Divide-by-zero is flagged with a one-cycle done/div_zero pulse and leaves hi/lo untouched.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           qsign_q, qsign_d;
    logic           rsign_q, rsign_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           dz_q, dz_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;

    logic [W:0]     shifted_rem;
    logic [W:0]     trial;

    // Partial remainder always stays below the divisor, so 32 stored bits suffice;
    // the 33-bit trial carries the sign of the subtraction.
    always_comb begin
        state_d     = state_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        qsign_d     = qsign_q;
        rsign_d     = rsign_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dz_d        = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        shifted_rem = {rem_q, quo_q[W-1]};
        trial       = shifted_rem - {1'b0, dvs_q};

        case (state_q)
            IDLE: begin
                if (div_start) begin
                    if (divisor == '0) begin
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else begin
                        quo_d   = dividend[W-1] ? W'(-dividend) : dividend;
                        dvs_d   = divisor[W-1]  ? W'(-divisor)  : divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                        qsign_d = dividend[W-1] ^ divisor[W-1];
                        rsign_d = dividend[W-1];
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = trial[W] ? shifted_rem[W-1:0] : trial[W-1:0];
                quo_d = {quo_q[W-2:0], ~trial[W]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                lo_d    = qsign_q ? W'(-quo_q) : quo_q;
                hi_d    = rsign_q ? W'(-rem_q) : rem_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            quo_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: transaction-level model (64-bit signed arithmetic plus a latency
// countdown) checked every cycle, with directed cases pinned to hand-computed values.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .div_start (div_start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, sq, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sq = sa / sb;
        sr = sa % sb;
        q  = sq[31:0];
        r  = sr[31:0];
    endfunction

    // Reference model: a result appears 33 edges after an accepted start.
    logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          cd = 0;

    always @(posedge clk or posedge reset) begin
        logic [31:0] q, r;
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
            m_hi   <= '0;   m_lo   <= '0;   cd   <= 0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (cd > 0) begin
                cd <= cd - 1;
                if (cd == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                end
            end else if (div_start) begin
                if (divisor == 32'd0) begin
                    m_done <= 1'b1;
                    m_dz   <= 1'b1;
                end else begin
                    ref_div(dividend, divisor, q, r);
                    p_lo   <= q;
                    p_hi   <= r;
                    m_busy <= 1'b1;
                    cd     <= 33;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("div_zero", 32'(div_zero), 32'(m_dz));
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    end

    // Called at a falling edge; returns at the falling edge just after the start edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        div_start = 1'b1;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        div_start = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) bcnt++;
        end
    endtask

    task automatic do_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi);
        int c, bc;
        start_op(a, b);
        wait_done(c, bc);
        check({nm, "_latency"}, 32'(c), 32'd33);
        check({nm, "_busy_cycles"}, 32'(bc), 32'd33);
        check({nm, "_lo"}, lo, elo);
        check({nm, "_hi"}, hi, ehi);
        check({nm, "_dz"}, 32'(div_zero), 32'd0);
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'd1;
            4:       v = $urandom >> $urandom_range(0, 31);
            5:       v = 32'(-int'($urandom_range(1, 100)));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int c, bc;
        reset     = 1'b1;
        div_start = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_div("pos", 32'd100, 32'd7, 32'd14, 32'd2);
        do_div("negdvd", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        do_div("negdvs", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
        do_div("preload", 32'd100, 32'd7, 32'd14, 32'd2);

        start_op(32'd5, 32'd0);
        check("dz_done", 32'(done), 32'd1);
        check("dz_flag", 32'(div_zero), 32'd1);
        check("dz_busy", 32'(busy), 32'd0);
        check("dz_hi", hi, 32'd2);
        check("dz_lo", lo, 32'd14);
        @(negedge clk);
        check("dz_done_clear", 32'(done), 32'd0);

        do_div("minneg1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        do_div("min2", 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0);

        start_op(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        div_start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        div_start = 1'b0;
        wait_done(c, bc);
        check("ign_latency", 32'(c), 32'd23);
        check("ign_lo", lo, 32'd14);
        check("ign_hi", hi, 32'd2);
        do_div("b2b", 32'd9, 32'd3, 32'd3, 32'd0);

        start_op(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        do_div("after_rst", 32'd50, 32'd5, 32'd10, 32'd0);

        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            div_start = ($urandom_range(0, 3) == 0);
            dividend  = rand_val();
            divisor   = rand_val();
        end
        @(negedge clk);
        div_start = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
